// File: rtl/pll_lock_supervisor.sv
// Supervises the PLL lock flag and issues a stretched, clean reset plus a ready flag to the PLL clock domain.
// Latency: SYNC_STAGES+1 edges from locked_async to a state change; outputs follow next-state and are registered.
// Backpressure: none; status flags are sticky until clear, and loss_count saturates.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4800,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 480000,
    parameter int CNT_W          = 8
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             locked_async,
    input  logic             clear,
    output logic             domain_reset_n,
    output logic             ready,
    output logic             lock_timeout,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count,
    output logic [1:0]       state
);

    localparam int MAX_SH = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
    localparam int TW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [TW-1:0]    STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0]    HOLD_LAST    = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        STABILIZE = 2'b01,
        RUN       = 2'b10,
        HOLD      = 2'b11
    } state_t;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || STABLE_CYCLES < 1 ||
        HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1 || CNT_W < 1) begin : g_param_err
        $error("pll_lock_supervisor: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    state_t                 state_q, state_nxt;
    logic [TW-1:0]          timer_q, timer_nxt;
    logic                   to_fired_q;
    logic                   run_nxt;
    logic                   loss_evt;
    logic                   timeout_hit;
    logic                   state_chg;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked_async};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            timer_q <= '0;
        end else begin
            state_q <= state_nxt;
            timer_q <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        timer_nxt = timer_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABILIZE;
                end else if (timer_q != TIMEOUT_LAST) begin
                    timer_nxt = timer_q + 1'b1;
                end
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (timer_q == STABLE_LAST) begin
                    state_nxt = RUN;
                end else begin
                    timer_nxt = timer_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Hold length is fixed; a returning lock is ignored here.
                if (timer_q == HOLD_LAST) begin
                    state_nxt = WAIT_LOCK;
                end else begin
                    timer_nxt = timer_q + 1'b1;
                end
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase
        if (state_nxt != state_q) begin
            timer_nxt = '0;
        end
    end

    always_comb begin
        run_nxt     = (state_nxt == RUN);
        state_chg   = (state_nxt != state_q);
        loss_evt    = (state_q == RUN) && !lock_s;
        // The timer saturates at the last value, so fire only once per WAIT_LOCK visit.
        timeout_hit = (state_q == WAIT_LOCK) && (timer_q == TIMEOUT_LAST) && !to_fired_q;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            domain_reset_n <= 1'b0;
            ready          <= 1'b0;
        end else begin
            domain_reset_n <= run_nxt;
            ready          <= run_nxt;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            to_fired_q <= 1'b0;
        end else if (state_chg) begin
            to_fired_q <= 1'b0;
        end else if (timeout_hit) begin
            to_fired_q <= 1'b1;
        end
    end

    // Set events take priority over a coincident clear.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            lock_timeout <= 1'b0;
            lock_lost    <= 1'b0;
            loss_count   <= '0;
        end else begin
            if (timeout_hit) begin
                lock_timeout <= 1'b1;
            end else if (clear) begin
                lock_timeout <= 1'b0;
            end

            if (loss_evt) begin
                lock_lost <= 1'b1;
                if (clear) begin
                    loss_count <= CNT_W'(1);
                end else if (loss_count != CNT_MAX) begin
                    loss_count <= loss_count + 1'b1;
                end
            end else if (clear) begin
                lock_lost  <= 1'b0;
                loss_count <= '0;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters.
// Inputs change and outputs are sampled on the falling edge of clock_in.
module tb_pll_lock_supervisor;

    logic       clock_in;
    logic       reset_n;
    logic       locked_async;
    logic       clear;
    logic       domain_reset_n;
    logic       ready;
    logic       lock_timeout;
    logic       lock_lost;
    logic [1:0] loss_count;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    pll_lock_supervisor #(
        .SYNC_STAGES(2),
        .STABLE_CYCLES(8),
        .HOLD_CYCLES(4),
        .TIMEOUT_CYCLES(32),
        .CNT_W(2)
    ) dut (
        .clock_in(clock_in),
        .reset_n(reset_n),
        .locked_async(locked_async),
        .clear(clear),
        .domain_reset_n(domain_reset_n),
        .ready(ready),
        .lock_timeout(lock_timeout),
        .lock_lost(lock_lost),
        .loss_count(loss_count),
        .state(state)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic chk_zero_status(input string tag);
        chk({tag, "_drn"}, 32'(domain_reset_n), 0);
        chk({tag, "_rdy"}, 32'(ready), 0);
        chk({tag, "_st"}, 32'(state), 0);
        chk({tag, "_to"}, 32'(lock_timeout), 0);
        chk({tag, "_ll"}, 32'(lock_lost), 0);
        chk({tag, "_cnt"}, 32'(loss_count), 0);
    endtask

    // Leaves the bench at a falling edge with reset just released (edge count 0).
    task automatic do_reset(input logic lk);
        reset_n      = 1'b0;
        locked_async = lk;
        clear        = 1'b0;
        step(2);
        chk_zero_status("rst");
        reset_n = 1'b1;
    endtask

    // One-cycle lock drop from RUN; HOLD is entered two edges after the drop is sampled.
    task automatic lose_lock(input logic with_clear, input int exp_cnt);
        locked_async = 1'b0;
        step(1);
        locked_async = 1'b1;
        step(1);
        chk("loss_pre_st", 32'(state), 2);
        clear = with_clear;
        step(1);
        clear = 1'b0;
        chk("loss_hold_st", 32'(state), 3);
        chk("loss_hold_drn", 32'(domain_reset_n), 0);
        chk("loss_ll", 32'(lock_lost), 1);
        chk("loss_cnt", 32'(loss_count), 32'(exp_cnt));
        step(3);
        chk("loss_hold_end", 32'(state), 3);
        step(1);
        chk("loss_wait", 32'(state), 0);
        step(1);
        chk("loss_stab", 32'(state), 1);
        step(7);
        chk("loss_stab_end_drn", 32'(domain_reset_n), 0);
        step(1);
        chk("loss_run_st", 32'(state), 2);
        chk("loss_run_rdy", 32'(ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        locked_async = 1'b0;
        clear        = 1'b0;

        // Lock present from reset release.
        do_reset(1'b1);
        step(2);
        chk("s1_e2_st", 32'(state), 0);
        step(1);
        chk("s1_e3_st", 32'(state), 1);
        step(7);
        chk("s1_e10_st", 32'(state), 1);
        chk("s1_e10_drn", 32'(domain_reset_n), 0);
        chk("s1_e10_rdy", 32'(ready), 0);
        step(1);
        chk("s1_e11_st", 32'(state), 2);
        chk("s1_e11_drn", 32'(domain_reset_n), 1);
        chk("s1_e11_rdy", 32'(ready), 1);
        chk("s1_cnt", 32'(loss_count), 0);

        // Single loss, then saturation of the loss counter.
        lose_lock(1'b0, 1);
        for (int i = 2; i <= 5; i++) begin
            lose_lock(1'b0, (i > 3) ? 3 : i);
        end
        lose_lock(1'b1, 1);

        // A bare clear in RUN zeroes the status without touching state.
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("clr_ll", 32'(lock_lost), 0);
        chk("clr_cnt", 32'(loss_count), 0);
        chk("clr_st", 32'(state), 2);

        // Asynchronous reset in RUN.
        step(2);
        #2 reset_n = 1'b0;
        #1;
        chk_zero_status("mid_rst");
        step(2);
        reset_n = 1'b1;
        step(10);
        chk("mid_rst_e10_drn", 32'(domain_reset_n), 0);
        step(1);
        chk("mid_rst_e11_drn", 32'(domain_reset_n), 1);

        // Lock drop during STABILIZE is not a loss event.
        do_reset(1'b1);
        step(6);
        chk("s2_e6_st", 32'(state), 1);
        locked_async = 1'b0;
        step(3);
        locked_async = 1'b1;
        chk("s2_e9_st", 32'(state), 0);
        step(2);
        chk("s2_e11_st", 32'(state), 0);
        chk("s2_e11_drn", 32'(domain_reset_n), 0);
        step(1);
        chk("s2_e12_st", 32'(state), 1);
        step(7);
        chk("s2_e19_st", 32'(state), 1);
        step(1);
        chk("s2_e20_st", 32'(state), 2);
        chk("s2_e20_drn", 32'(domain_reset_n), 1);
        chk("s2_ll", 32'(lock_lost), 0);
        chk("s2_cnt", 32'(loss_count), 0);

        // Lock acquisition timeout.
        do_reset(1'b0);
        step(30);
        chk("s4_e30_to", 32'(lock_timeout), 0);
        step(4);
        chk("s4_e34_to", 32'(lock_timeout), 1);
        chk("s4_e34_st", 32'(state), 0);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("s4_clr_to", 32'(lock_timeout), 0);
        step(5);
        chk("s4_norearm_to", 32'(lock_timeout), 0);
        chk("s4_norearm_st", 32'(state), 0);
        locked_async = 1'b1;
        step(3);
        chk("s4_stab_st", 32'(state), 1);
        step(7);
        chk("s4_stab_end_st", 32'(state), 1);
        step(1);
        chk("s4_run_st", 32'(state), 2);
        chk("s4_run_drn", 32'(domain_reset_n), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
